// File: rtl/truth_table_sweeper_if.sv
// Bundle between the start/status controller, the swept DUT and truth_table_sweeper.
interface truth_table_sweeper_if #(
  parameter int unsigned N_IN    = 3,
  parameter int unsigned DWELL_W = 4
);
  localparam int unsigned T = 1 << N_IN;

  logic               start;
  logic [DWELL_W-1:0] dwell;
  logic [T-1:0]       expected;
  logic [N_IN-1:0]    vec_out;
  logic               f_in;
  logic               busy;
  logic               done;
  logic               pass;
  logic [T-1:0]       table_out;
  logic [N_IN:0]      mismatch_cnt;

  modport master (
    output start, dwell, expected, f_in,
    input  vec_out, busy, done, pass, table_out, mismatch_cnt
  );

  modport slave (
    input  start, dwell, expected, f_in,
    output vec_out, busy, done, pass, table_out, mismatch_cnt
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks all 2^N_IN input vectors with a programmable dwell, captures and checks the truth table.
// Optional macro TTS_STOP_ON_FAIL_EN ends the sweep on the first mismatching sample.
module truth_table_sweeper #(
  parameter int unsigned N_IN    = 3,
  parameter int unsigned DWELL_W = 4
) (
  input logic                   clk,
  input logic                   rst,
  truth_table_sweeper_if.slave  bus
);
  localparam int unsigned T = 1 << N_IN;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [N_IN-1:0]    vec_q, vec_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [T-1:0]       exp_q, exp_d;
  logic [T-1:0]       table_q, table_d;
  logic [N_IN:0]      mcnt_q, mcnt_d;
  logic               pass_q, pass_d;
  logic               mis;
  logic               last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      exp_q   <= '0;
      table_q <= '0;
      mcnt_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      mcnt_q  <= mcnt_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    exp_d   = exp_q;
    table_d = table_q;
    mcnt_d  = mcnt_q;
    pass_d  = pass_q;
    mis     = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dwell_d = bus.dwell;
          exp_d   = bus.expected;
          table_d = '0;
          mcnt_d  = '0;
          pass_d  = 1'b0;
          vec_d   = '0;
          cnt_d   = '0;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_q != dwell_q) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          // end of hold: capture the DUT response for the current vector
          cnt_d          = '0;
          table_d[vec_q] = bus.f_in;
          mis            = bus.f_in != exp_q[vec_q];
          if (mis) mcnt_d = mcnt_q + 1'b1;
`ifdef TTS_STOP_ON_FAIL_EN
          last = (&vec_q) | mis;
`else
          last = &vec_q;
`endif
          if (last) begin
            vec_d   = '0;
            pass_d  = (mcnt_d == '0);
            state_d = S_DONE;
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // status outputs decode straight from registered state
  assign bus.vec_out      = vec_q;
  assign bus.busy         = (state_q == S_DRIVE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.pass         = pass_q;
  assign bus.table_out    = table_q;
  assign bus.mismatch_cnt = mcnt_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized bench for truth_table_sweeper against a sample-count based reference model.
module tb_truth_table_sweeper;
  localparam int unsigned N_IN    = 3;
  localparam int unsigned DWELL_W = 4;
  localparam int unsigned T       = 1 << N_IN;
  localparam int M_IDLE  = 0;
  localparam int M_SWEEP = 1;
  localparam int M_DONE  = 2;

  logic clk = 1'b0;
  logic rst;
  logic [T-1:0] dut_tab;
  logic cmp_en = 1'b0;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(N_IN), .DWELL_W(DWELL_W)) bus ();
  truth_table_sweeper #(.N_IN(N_IN), .DWELL_W(DWELL_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // combinational DUT under test: an arbitrary truth table lookup
  assign bus.f_in = dut_tab[bus.vec_out];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
  endtask

  function automatic logic [T-1:0] lowmask(input int s);
    logic [T-1:0] m = '0;
    for (int i = 0; i < s && i < int'(T); i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic int popc(input logic [T-1:0] v);
    int c = 0;
    for (int i = 0; i < int'(T); i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int exp_lat(input logic [T-1:0] tab, input logic [T-1:0] ev, input int d);
`ifdef TTS_STOP_ON_FAIL_EN
    for (int k = 0; k < int'(T); k++) if (tab[k] != ev[k]) return (k + 1) * d;
`endif
    return int'(T) * d;
  endfunction

  // reference model: m_n edges since the start edge, m_d = hold length
  int m_mode = M_IDLE;
  int m_n = 0;
  int m_d = 1;
  logic [T-1:0] m_exp = '0, m_tab = '0, h_table = '0;
  int h_mc = 0;
  bit m_pass = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_IDLE; h_table = '0; h_mc = 0; m_pass = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: if (bus.start) begin
          m_mode = M_SWEEP; m_n = 0; m_d = int'(bus.dwell) + 1;
          m_exp = bus.expected; m_tab = dut_tab; m_pass = 1'b0;
        end
        M_SWEEP: begin
          m_n++;
          if (m_n == int'(T) * m_d) m_mode = M_DONE;
`ifdef TTS_STOP_ON_FAIL_EN
          if (m_n % m_d == 0 && m_tab[m_n / m_d - 1] != m_exp[m_n / m_d - 1]) m_mode = M_DONE;
`endif
          if (m_mode == M_DONE) begin
            h_table = m_tab & lowmask(m_n / m_d);
            h_mc    = popc((m_tab ^ m_exp) & lowmask(m_n / m_d));
            m_pass  = (h_mc == 0);
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  logic [T-1:0] e_tab;
  int e_mc, e_vec;
  bit e_busy, e_done, e_pass;

  always @(negedge clk) begin
    if (cmp_en) begin
      e_tab = h_table; e_mc = h_mc; e_vec = 0; e_busy = 0; e_done = 0; e_pass = m_pass;
      if (m_mode == M_SWEEP) begin
        e_tab  = m_tab & lowmask(m_n / m_d);
        e_mc   = popc((m_tab ^ m_exp) & lowmask(m_n / m_d));
        e_vec  = m_n / m_d;
        e_busy = 1; e_pass = 0;
      end else if (m_mode == M_DONE) begin
        e_done = 1;
      end
      chk("vec_out", 32'(bus.vec_out), 32'(e_vec));
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("done", 32'(bus.done), 32'(e_done));
      chk("pass", 32'(bus.pass), 32'(e_pass));
      chk("table_out", 32'(bus.table_out), 32'(e_tab));
      chk("mismatch_cnt", 32'(bus.mismatch_cnt), 32'(e_mc));
    end
  end

  task automatic run_sweep(input logic [T-1:0] tab, input logic [T-1:0] ev, input int dw,
                           input bit mutate, output int lat);
    @(negedge clk);
    dut_tab = tab; bus.expected = ev; bus.dwell = DWELL_W'(dw); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 400) begin
      @(negedge clk);
      lat++;
      if (mutate && lat == 3) begin
        bus.dwell = DWELL_W'($urandom);
        bus.expected = T'($urandom);
      end
    end
    if (!bus.done) begin
      n_chk++;
      $display("FAIL done_timeout: no done within %0d cycles", lat);
    end
  endtask

  int lat, pulses, waitc;
  logic [T-1:0] tab, ev;
  int dw;

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.dwell = '0; bus.expected = '0; dut_tab = '0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_vec", 32'(bus.vec_out), 0);
    chk("rst_table", 32'(bus.table_out), 0);
    chk("rst_pass", 32'(bus.pass), 0);
    rst = 1'b0;

    // majority DUT, zero dwell
    run_sweep(8'hE8, 8'hE8, 0, 1'b0, lat);
    chk("maj_lat", 32'(lat), 8);
    chk("maj_table", 32'(bus.table_out), 32'h E8);
    chk("maj_mc", 32'(bus.mismatch_cnt), 0);
    chk("maj_pass", 32'(bus.pass), 1);

    // long dwell with dwell/expected disturbed mid-sweep
    run_sweep(8'hE8, 8'hE8, 6, 1'b1, lat);
    chk("dw6_lat", 32'(lat), 56);
    chk("dw6_pass", 32'(bus.pass), 1);

    // single wrong bit (index 5)
    run_sweep(8'hE8, 8'hC8, 0, 1'b0, lat);
    chk("bad_lat", 32'(lat), 32'(exp_lat(8'hE8, 8'hC8, 1)));
    chk("bad_mc", 32'(bus.mismatch_cnt), 1);
    chk("bad_pass", 32'(bus.pass), 0);

    // reset in the middle of a sweep
    @(negedge clk);
    dut_tab = 8'hE8; bus.expected = 8'hE8; bus.dwell = 4'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitc = 0;
    while (bus.vec_out != 3'd4 && waitc < 50) begin @(negedge clk); waitc++; end
    chk("mid_vec", 32'(bus.vec_out), 4);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_vec", 32'(bus.vec_out), 0);
    chk("mrst_busy", 32'(bus.busy), 0);
    chk("mrst_table", 32'(bus.table_out), 0);
    chk("mrst_mc", 32'(bus.mismatch_cnt), 0);
    rst = 1'b0;
    run_sweep(8'hE8, 8'hE8, 0, 1'b0, lat);
    chk("post_rst_pass", 32'(bus.pass), 1);

    // start held high: back-to-back sweeps every 10 cycles
    @(negedge clk);
    dut_tab = 8'hE8; bus.expected = 8'hE8; bus.dwell = '0; bus.start = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    bus.start = 1'b0;
    chk("cont_pulses", 32'(pulses), 4);

    // randomized sweeps
    for (int it = 0; it < 25; it++) begin
      tab = T'($urandom);
      ev  = ($urandom_range(0, 1) == 1) ? tab : (tab ^ T'($urandom));
      dw  = int'($urandom_range(0, 15));
      run_sweep(tab, ev, dw, 1'($urandom_range(0, 1)), lat);
      chk("rand_lat", 32'(lat), 32'(exp_lat(tab, ev, dw + 1)));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
